dmem_responder: RTL and testbench

Memory-side responder for the CPU's data-memory port. It accepts one load or store request at a time over a valid/ready handshake and services it from an internal byte-addressed, little-endian store. Each request gets a response after a fixed, parameterised latency; the response is held until the pipeline consumes it. It is the slave end that the EX/MEM stage drives once memory becomes multi-cycle and memory stalls replace single-cycle access.

---
 rtl/dmem_if.sv | 23 ++
 rtl/dmem_responder.sv | 139 +++++++++++++
 tb/tb_dmem_responder.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/dmem_if.sv
// Data-memory port bundle between the EX/MEM stage (master) and the memory responder (slave).
interface dmem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [63:0] req_addr;
    logic [3:0]  req_size;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_size, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_size, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with a little-endian byte store; response after LATENCY cycles.
// req_ready only in IDLE; the response is held stable until resp_ready.
module dmem_responder #(
    parameter int DEPTH_WORDS = 128,
    parameter int LATENCY     = 2
) (
    input  logic     clk,
    input  logic     reset,
    dmem_if.slave    bus
);
    localparam int          IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [64:0] LIMIT    = 65'(DEPTH_WORDS) << 3;
    localparam logic [3:0]  CNT_INIT = 4'((LATENCY > 1) ? LATENCY - 2 : 0);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        resp_valid_q, resp_valid_d;
    logic [63:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;

    logic [63:0] mem [DEPTH_WORDS];

    logic             size_ok, align_ok, range_ok, req_err;
    logic [2:0]       off;
    logic [IDX_W-1:0] widx;
    logic [7:0]       size_mask, byte_en;
    logic [63:0]      wdata_sh, rword, rshift, load_data;
    logic             accept, mem_we;

    // Request decode; every check uses the live request fields, which are only
    // consumed on the acceptance edge.
    always_comb begin
        size_ok   = 1'b0;
        align_ok  = 1'b0;
        size_mask = 8'h00;
        case (bus.req_size)
            4'd1: begin size_ok = 1'b1; align_ok = 1'b1;                      size_mask = 8'h01; end
            4'd2: begin size_ok = 1'b1; align_ok = (bus.req_addr[0] == 1'b0);   size_mask = 8'h03; end
            4'd4: begin size_ok = 1'b1; align_ok = (bus.req_addr[1:0] == 2'b0); size_mask = 8'h0F; end
            4'd8: begin size_ok = 1'b1; align_ok = (bus.req_addr[2:0] == 3'b0); size_mask = 8'hFF; end
            default: ;
        endcase
        // 65-bit sum so addresses near 2^64 cannot wrap into range
        range_ok = (({1'b0, bus.req_addr} + 65'(bus.req_size)) <= LIMIT);
        req_err  = !(size_ok && align_ok && range_ok);

        off      = bus.req_addr[2:0];
        widx     = bus.req_addr[IDX_W+2:3];
        byte_en  = size_mask << off;
        wdata_sh = bus.req_wdata << {off, 3'b000};
        rword    = mem[widx];
        rshift   = rword >> {off, 3'b000};

        load_data = 64'd0;
        case (bus.req_size)
            4'd1:    load_data = {56'd0, rshift[7:0]};
            4'd2:    load_data = {48'd0, rshift[15:0]};
            4'd4:    load_data = {32'd0, rshift[31:0]};
            4'd8:    load_data = rshift;
            default: load_data = 64'd0;
        endcase

        accept = bus.req_valid && (state_q == IDLE) && !reset;
        mem_we = accept && bus.req_write && !req_err;
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    resp_err_d   = req_err;
                    resp_rdata_d = (bus.req_write || req_err) ? 64'd0 : load_data;
                    if (LATENCY > 1) begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d      = IDLE;
                resp_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 64'd0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 8; b++) begin
                if (byte_en[b]) mem[widx][8*b +: 8] <= wdata_sh[8*b +: 8];
            end
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: LATENCY=2 instance for function/backpressure/reset, LATENCY=1 instance for back-to-back.
module tb_dmem_responder;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;
    int   acc_q[$];
    logic [63:0] rsp_q[$];

    always #5 clk = ~clk;

    dmem_if if2();
    dmem_if if1();

    dmem_responder #(.DEPTH_WORDS(128), .LATENCY(2)) u_dut2 (.clk(clk), .reset(reset), .bus(if2));
    dmem_responder #(.DEPTH_WORDS(128), .LATENCY(1)) u_dut1 (.clk(clk), .reset(reset), .bus(if1));

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mon_en && if1.req_valid && if1.req_ready) acc_q.push_back(cyc);
        if (mon_en && if1.resp_valid && if1.resp_ready) rsp_q.push_back(if1.resp_rdata);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic issue2(input logic wr, input logic [63:0] addr, input logic [3:0] size,
                          input logic [63:0] wd, output logic [63:0] rd, output logic er,
                          output int lat);
        @(negedge clk);
        if2.req_valid = 1'b1;
        if2.req_write = wr;
        if2.req_addr  = addr;
        if2.req_size  = size;
        if2.req_wdata = wd;
        @(posedge clk);
        #1;
        if2.req_valid = 1'b0;
        if2.req_wdata = '1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!if2.resp_valid && lat < 20);
        rd = if2.resp_rdata;
        er = if2.resp_err;
        @(posedge clk);
        #1;
    endtask

    task automatic txn(input string tag, input logic wr, input logic [63:0] addr,
                       input logic [3:0] size, input logic [63:0] wd,
                       input logic [63:0] exp_rd, input logic exp_er);
        logic [63:0] rd;
        logic        er;
        int          lat;
        issue2(wr, addr, size, wd, rd, er, lat);
        chk({tag, "_lat"}, 64'(lat), 64'd2);
        chk({tag, "_rdata"}, rd, exp_rd);
        chk({tag, "_err"}, 64'(er), {63'd0, exp_er});
    endtask

    task automatic drive1(input logic wr, input logic [63:0] addr, input logic [3:0] size,
                          input logic [63:0] wd);
        int guard = 0;
        while (!if1.req_ready && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 10) chk("b2b_ready_timeout", 64'd0, 64'd1);
        if1.req_valid = 1'b1;
        if1.req_write = wr;
        if1.req_addr  = addr;
        if1.req_size  = size;
        if1.req_wdata = wd;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [63:0] exp_ld [4];
        int          guard;
        bit          stale;

        if2.req_valid = 1'b0; if2.req_write = 1'b0; if2.req_addr = '0;
        if2.req_size = 4'd8;  if2.req_wdata = '0;   if2.resp_ready = 1'b1;
        if1.req_valid = 1'b0; if1.req_write = 1'b0; if1.req_addr = '0;
        if1.req_size = 4'd8;  if1.req_wdata = '0;   if1.resp_ready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 64'(if2.req_ready), 64'd1);
        chk("rst_resp_valid", 64'(if2.resp_valid), 64'd0);
        chk("rst_resp_rdata", if2.resp_rdata, 64'd0);
        chk("rst_resp_err", 64'(if2.resp_err), 64'd0);
        reset = 1'b0;

        // Basic store/load and sub-word merge
        txn("st_10", 1'b1, 64'h10, 4'd8, 64'h1122334455667788, 64'd0, 1'b0);
        txn("ld_10", 1'b0, 64'h10, 4'd8, 64'd0, 64'h1122334455667788, 1'b0);
        txn("st_13b", 1'b1, 64'h13, 4'd1, 64'hDEADBEEFCAFE00AB, 64'd0, 1'b0);
        txn("ld_10m", 1'b0, 64'h10, 4'd8, 64'd0, 64'h11223344AB667788, 1'b0);
        txn("ld_12h", 1'b0, 64'h12, 4'd2, 64'd0, 64'h000000000000AB66, 1'b0);

        // Known contents at word 0 and the last word before the error cases
        txn("st_00", 1'b1, 64'h0, 4'd8, 64'h0102030405060708, 64'd0, 1'b0);
        txn("st_last", 1'b1, 64'h3F8, 4'd8, 64'hCAFEBABE12345678, 64'd0, 1'b0);
        txn("ld_last", 1'b0, 64'h3F8, 4'd8, 64'd0, 64'hCAFEBABE12345678, 1'b0);

        txn("e_misal", 1'b1, 64'h12, 4'd4, 64'hFFFFFFFFFFFFFFFF, 64'd0, 1'b1);
        txn("e_range", 1'b0, 64'h400, 4'd8, 64'd0, 64'd0, 1'b1);
        txn("e_size3", 1'b1, 64'h0, 4'd3, 64'hFFFFFFFFFFFFFFFF, 64'd0, 1'b1);
        txn("e_wrap", 1'b0, 64'hFFFFFFFFFFFFFFF8, 4'd8, 64'd0, 64'd0, 1'b1);
        txn("e_wrap_st", 1'b1, 64'hFFFFFFFFFFFFFFF8, 4'd8, 64'hFFFFFFFFFFFFFFFF, 64'd0, 1'b1);
        txn("keep_10", 1'b0, 64'h10, 4'd8, 64'd0, 64'h11223344AB667788, 1'b0);
        txn("keep_00", 1'b0, 64'h0, 4'd8, 64'd0, 64'h0102030405060708, 1'b0);
        txn("keep_last", 1'b0, 64'h3F8, 4'd8, 64'd0, 64'hCAFEBABE12345678, 1'b0);

        // Response backpressure with an ignored request pulse in the window
        @(negedge clk);
        if2.req_valid = 1'b1; if2.req_write = 1'b0; if2.req_addr = 64'h10; if2.req_size = 4'd8;
        @(posedge clk);
        #1;
        if2.req_valid = 1'b0;
        if2.resp_ready = 1'b0;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!if2.resp_valid && guard < 20);
        chk("bp_wait", 64'(guard), 64'd2);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 64'(if2.resp_valid), 64'd1);
            chk("bp_rdata", if2.resp_rdata, 64'h11223344AB667788);
            chk("bp_err", 64'(if2.resp_err), 64'd0);
            chk("bp_req_ready", 64'(if2.req_ready), 64'd0);
            if (i == 1) begin
                if2.req_valid = 1'b1; if2.req_write = 1'b1; if2.req_addr = 64'h10;
                if2.req_size = 4'd8;  if2.req_wdata = 64'd0;
            end else begin
                if2.req_valid = 1'b0;
            end
            @(negedge clk);
        end
        if2.req_valid = 1'b0;
        if2.resp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 64'(if2.req_ready), 64'd1);
        chk("bp_release_valid", 64'(if2.resp_valid), 64'd0);
        txn("bp_ignored", 1'b0, 64'h10, 4'd8, 64'd0, 64'h11223344AB667788, 1'b0);

        // LATENCY=1 back-to-back: stores, then four continuous loads
        @(negedge clk);
        drive1(1'b1, 64'h20, 4'd8, 64'hA0A1A2A3A4A5A6A7);
        drive1(1'b1, 64'h28, 4'd8, 64'hB0B1B2B3B4B5B6B7);
        drive1(1'b1, 64'h30, 4'd8, 64'hC0C1C2C3C4C5C6C7);
        drive1(1'b1, 64'h38, 4'd8, 64'hD0D1D2D3D4D5D6D7);
        if1.req_valid = 1'b0;
        repeat (3) @(negedge clk);
        mon_en = 1'b1;
        drive1(1'b0, 64'h20, 4'd8, 64'd0);
        drive1(1'b0, 64'h2C, 4'd4, 64'd0);
        drive1(1'b0, 64'h36, 4'd2, 64'd0);
        drive1(1'b0, 64'h38, 4'd1, 64'd0);
        if1.req_valid = 1'b0;
        guard = 0;
        while (rsp_q.size() < 4 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        mon_en = 1'b0;
        chk("b2b_acc_count", 64'(acc_q.size()), 64'd4);
        chk("b2b_rsp_count", 64'(rsp_q.size()), 64'd4);
        exp_ld[0] = 64'hA0A1A2A3A4A5A6A7;
        exp_ld[1] = 64'h00000000B0B1B2B3;
        exp_ld[2] = 64'h000000000000C0C1;
        exp_ld[3] = 64'h00000000000000D7;
        for (int i = 1; i < 4; i++)
            if (i < acc_q.size()) chk("b2b_spacing", 64'(acc_q[i] - acc_q[i-1]), 64'd2);
        for (int i = 0; i < 4; i++)
            if (i < rsp_q.size()) chk("b2b_rdata", rsp_q[i], exp_ld[i]);

        // Reset while a load is in WAIT
        @(negedge clk);
        if2.req_valid = 1'b1; if2.req_write = 1'b0; if2.req_addr = 64'h10; if2.req_size = 4'd8;
        @(posedge clk);
        #1;
        if2.req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mrst_resp_valid", 64'(if2.resp_valid), 64'd0);
        chk("mrst_req_ready", 64'(if2.req_ready), 64'd1);
        stale = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (if2.resp_valid) stale = 1'b1;
        end
        chk("mrst_no_stale", 64'(stale), 64'd0);
        txn("mrst_keep_10", 1'b0, 64'h10, 4'd8, 64'd0, 64'h11223344AB667788, 1'b0);
        txn("mrst_keep_last", 1'b0, 64'h3F8, 4'd8, 64'd0, 64'hCAFEBABE12345678, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
